irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt sequencer for the 16-bit program counter block.
- Latches edge-triggered requests from NUM_IRQ sources, masks them and selects one by fixed priority.
- At an instruction commit boundary it asserts the PC block's interrupt/isr_target inputs, saves the return PC, and drives isr_return until MRET commits.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..8).
- VEC_BASE, 16'h0010, vector address of source 0.
- VEC_STRIDE, 4, byte distance between vectors; must be a multiple of 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw request lines; a rising edge makes a request pending.
- commit_valid  in  1  core retires an instruction this cycle (same cycle as pcflag).
- mret_commit  in  1  retiring instruction is MRET (core drives jump=2'b11).
- pc_next  in  16  PC the retiring instruction would load if not interrupted.
- cfg_we  in  1  configuration write strobe.
- cfg_wdata  in  NUM_IRQ+1  bit NUM_IRQ = global enable (gie); bits NUM_IRQ-1:0 = mask.
- cfg_rdata  out  NUM_IRQ+1  current {gie, mask}.
- interrupt  out  1  take-interrupt strobe to the PC block.
- isr_target  out  16  vector address for the selected source.
- isr_return  out  16  saved return PC (epc).
- in_service  out  1  handler active.
- active_id  out  3  source index being serviced.
- pending  out  NUM_IRQ  pending request bits.
- mret_spurious  out  1  one-cycle pulse: MRET committed while not in service.

Behaviour:
- Reset values: state IDLE; pending, mask, gie, epc, active_id all 0. All outputs are therefore 0; isr_target shows VEC_BASE.
- Edge detect: registered prev_irq; rise = irq_in & ~prev_irq sets pending[i] on the next clk.
- Pending arbitration: a rise and a take-clear on the same bit in the same cycle → the bit stays set (set wins).
- Eligible set: elig = pending & mask. Selected index = lowest set bit of elig (index 0 is highest priority).
- isr_target = VEC_BASE + idx*VEC_STRIDE, computed combinationally and truncated to 16 bits.
- Take condition: state==IDLE & gie & |elig & commit_valid & ~mret_commit.
- interrupt is combinational (Mealy) and equals the take condition, so the PC block samples it on the same edge as pcflag.
- On take:
  - epc <= pc_next; active_id <= idx; pending[idx] <= 0; state -> IN_ISR.
- Minimum latency: irq rising edge in cycle N, pending set at edge N+1, interrupt at the earliest in cycle N+1 if that cycle commits.
- IN_ISR: no nesting; interrupt stays 0; new edges still accumulate in pending.
- mret_commit & commit_valid in IN_ISR → state -> IDLE at the next edge.
  - Re-take is possible in the first commit after return.
  - Nothing is taken on the MRET commit itself.
- mret_commit in IDLE → mret_spurious pulses for 1 cycle; no state change.
- isr_return = epc at all times.
- in_service = (state==IN_ISR).
- Config write:
  - Takes effect at the next edge; a take in the same cycle uses the old mask/gie.
  - Clearing a mask bit does not clear pending.
  - gie=0 during IN_ISR does not abort the handler.
- Reset asserted mid-handler: immediate return to IDLE, pending lost, interrupt deasserted asynchronously.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: two-flop synchronizer on each irq_in ahead of the edge detector. Adds 2 cycles, so minimum latency becomes N+3.
- Undefined: irq_in is assumed synchronous to clk and feeds the edge detector directly.

Decomposition:
- Package irq_seq_pkg:
  - state enum {IDLE, IN_ISR};
  - VEC_BASE/VEC_STRIDE defaults;
  - function vec_addr(idx).
- Sub-module irq_prio_enc: parametric lowest-index-first priority encoder; outputs idx and any_valid.

Test Plan:
- Reset, cfg {gie=1, mask=4'b0100}, pulse irq_in[2], commit with pc_next=16'h0040:
  - interrupt=1 for exactly that cycle, isr_target=16'h0018;
  - next cycle isr_return=16'h0040, in_service=1, active_id=2, pending[2]=0.
- Raise irq_in[1] and irq_in[3] together, mask=4'b1111 → first take targets 16'h0014. After MRET commit, next commit takes source 3 → 16'h001C.
- During IN_ISR pulse irq_in[0] → no interrupt, pending[0]=1. MRET commit → IDLE, no take that cycle; following commit takes source 0 → 16'h0010.
- gie=0 with pending[1]=1 and commits every cycle → interrupt stays 0. Write gie=1 → take on the first commit after the write edge.
- mret_commit in IDLE → mret_spurious=1 for one cycle, state unchanged, isr_return unchanged.
- Assert reset while in_service=1 → in_service, pending and isr_return read 0 before the next clk edge; a pre-reset irq edge is not serviced.

Source files
------------

// File: rtl/irq_seq_pkg.sv
// Shared types and defaults for the interrupt sequencer.
package irq_seq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_ISR = 1'b1
    } state_t;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0010;
    localparam int          VEC_STRIDE_DEF = 4;

    // Vector address of source idx; wraps at 16 bits like the PC does.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int          stride,
                                             input logic [2:0]  idx);
        int off;
        off = int'(idx) * stride;
        return base + off[15:0];
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         any_valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = 3'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the 16-bit PC block.
// Latches rising edges of irq_in as pending requests, masks them, picks the
// lowest enabled index and injects it at an instruction commit boundary.
// Optional build macro IRQ_SYNC_EN: adds a two-flop synchronizer on each
// irq_in ahead of the edge detector (two extra cycles of latency).
//
// Commit qualification: commit_valid marks the single cycle in which the core
// retires an instruction; mret_commit and pc_next are only meaningful while
// commit_valid is high. interrupt is asserted in that same cycle so the PC
// block samples it on the same edge as the retirement.
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               commit_valid,
    input  logic               mret_commit,
    input  logic [15:0]        pc_next,
    input  logic               cfg_we,
    input  logic [NUM_IRQ:0]   cfg_wdata,
    output logic [NUM_IRQ:0]   cfg_rdata,
    output logic               interrupt,
    output logic [15:0]        isr_target,
    output logic [15:0]        isr_return,
    output logic               in_service,
    output logic [2:0]         active_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               mret_spurious
);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic               gie_q;
    logic [15:0]        epc_q;
    logic [2:0]         active_q;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] take_clr;
    logic [2:0]         sel_idx;
    logic               any_elig;
    logic               take;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous request lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign rise = irq_s & ~prev_q;
    assign elig = pending_q & mask_q;

    irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
        .req       (elig),
        .idx       (sel_idx),
        .any_valid (any_elig)
    );

    // Next state plus the Mealy take/spurious strobes.
    always_comb begin
        state_d       = state_q;
        take          = 1'b0;
        mret_spurious = 1'b0;
        case (state_q)
            IDLE: begin
                if (gie_q && any_elig && commit_valid && !mret_commit) begin
                    take    = 1'b1;
                    state_d = IN_ISR;
                end
                mret_spurious = commit_valid && mret_commit;
            end
            IN_ISR: begin
                // No nesting: only the handler's MRET leaves this state.
                if (commit_valid && mret_commit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign take_clr = take ? (NUM_IRQ'(1) << sel_idx) : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Edge detector and pending bits; a new rise beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= irq_s;
            pending_q <= (pending_q & ~take_clr) | rise;
        end
    end

    // Configuration register; a same-cycle take still sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie_q  <= 1'b0;
            mask_q <= '0;
        end else if (cfg_we) begin
            gie_q  <= cfg_wdata[NUM_IRQ];
            mask_q <= cfg_wdata[NUM_IRQ-1:0];
        end
    end

    // Return PC and serviced source captured on take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q    <= '0;
            active_q <= '0;
        end else if (take) begin
            epc_q    <= pc_next;
            active_q <= sel_idx;
        end
    end

    assign interrupt  = take;
    assign isr_target = vec_addr(VEC_BASE, VEC_STRIDE, sel_idx);
    assign isr_return = epc_q;
    assign in_service = (state_q == IN_ISR);
    assign active_id  = active_q;
    assign pending    = pending_q;
    assign cfg_rdata  = {gie_q, mask_q};

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed vector table, reset-in-handler sequence,
// then random traffic against a cycle-level behavioural model.
module tb_irq_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        commit_valid;
    logic        mret_commit;
    logic [15:0] pc_next;
    logic        cfg_we;
    logic [4:0]  cfg_wdata;
    logic [4:0]  cfg_rdata;
    logic        interrupt;
    logic [15:0] isr_target;
    logic [15:0] isr_return;
    logic        in_service;
    logic [2:0]  active_id;
    logic [3:0]  pending;
    logic        mret_spurious;

    irq_sequencer dut (
        .clk           (clk),
        .reset         (rst),
        .irq_in        (irq_in),
        .commit_valid  (commit_valid),
        .mret_commit   (mret_commit),
        .pc_next       (pc_next),
        .cfg_we        (cfg_we),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .interrupt     (interrupt),
        .isr_target    (isr_target),
        .isr_return    (isr_return),
        .in_service    (in_service),
        .active_id     (active_id),
        .pending       (pending),
        .mret_spurious (mret_spurious)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    // Behavioural model state
    logic [3:0]  m_pend, m_mask, m_prev;
    logic        m_gie, m_svc;
    logic [15:0] m_epc;
    logic [2:0]  m_id;
`ifdef IRQ_SYNC_EN
    logic [3:0]  m_s1, m_s2;
`endif
    // Model's combinational view for the current cycle
    logic        e_int, e_spur;
    logic [15:0] e_tgt;

    typedef struct {
        logic [3:0]  irq;
        logic        cv;
        logic        mret;
        logic [15:0] pcn;
        logic        we;
        logic [4:0]  wd;
        logic        x_int;
        logic [15:0] x_tgt;
        logic        x_svc;
        logic [15:0] x_ret;
        logic [2:0]  x_id;
        logic [3:0]  x_pend;
        logic [4:0]  x_cfg;
        logic        x_spur;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_gie = 1'b0; m_svc = 1'b0; m_epc = '0; m_id = '0;
`ifdef IRQ_SYNC_EN
        m_s1 = '0; m_s2 = '0;
`endif
        exp_q.delete();
    endtask

    // Driver: apply one cycle of inputs at negedge, compare before the next
    // rising edge, then advance the model across that edge.
    task automatic step(input logic [3:0] irq, input logic cv, input logic mret,
                        input logic [15:0] pcn, input logic we, input logic [4:0] wd,
                        input logic use_model);
        logic [3:0] elig, rise_v, irq_eff;
        int         sel;
        logic       found;
        @(negedge clk);
        irq_in = irq; commit_valid = cv; mret_commit = mret;
        pc_next = pcn; cfg_we = we; cfg_wdata = wd;
        #1;
        elig  = m_pend & m_mask;
        sel   = 0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i] && !found) begin
                sel   = i;
                found = 1'b1;
            end
        end
        e_tgt  = 16'h0010 + 16'(sel * 4);
        e_int  = !m_svc && m_gie && found && cv && !mret;
        e_spur = !m_svc && cv && mret;
        if (use_model) begin
            chk("interrupt", 32'(interrupt), 32'(e_int));
            chk("isr_target", 32'(isr_target), 32'(e_tgt));
            chk("in_service", 32'(in_service), 32'(m_svc));
            chk("isr_return", 32'(isr_return), 32'(m_epc));
            chk("active_id", 32'(active_id), 32'(m_id));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("cfg_rdata", 32'(cfg_rdata), 32'({m_gie, m_mask}));
            chk("mret_spurious", 32'(mret_spurious), 32'(e_spur));
        end
        // Scoreboard: every observed take must match a predicted target.
        if (e_int) exp_q.push_back(e_tgt);
        if (interrupt) begin
            if (exp_q.size() == 0) chk("sb_unexpected_take", 32'(interrupt), 32'd0);
            else                   chk("sb_take_target", 32'(isr_target), 32'(exp_q.pop_front()));
        end
        // Advance the model across the coming edge.
`ifdef IRQ_SYNC_EN
        irq_eff = m_s2;
        m_s2 = m_s1;
        m_s1 = irq;
`else
        irq_eff = irq;
`endif
        rise_v = irq_eff & ~m_prev;
        m_prev = irq_eff;
        if (e_int) begin
            m_epc = pcn;
            m_id  = 3'(sel);
            m_pend[sel] = 1'b0;
            m_svc = 1'b1;
        end else if (m_svc && cv && mret) begin
            m_svc = 1'b0;
        end
        m_pend = m_pend | rise_v;
        if (we) begin
            m_gie  = wd[4];
            m_mask = wd[3:0];
        end
    endtask

    function automatic vec_t mk(input logic [3:0] irq, input logic cv, input logic mret,
                                input logic [15:0] pcn, input logic we, input logic [4:0] wd,
                                input logic x_int, input logic [15:0] x_tgt, input logic x_svc,
                                input logic [15:0] x_ret, input logic [2:0] x_id,
                                input logic [3:0] x_pend, input logic [4:0] x_cfg,
                                input logic x_spur);
        vec_t v;
        v.irq = irq; v.cv = cv; v.mret = mret; v.pcn = pcn; v.we = we; v.wd = wd;
        v.x_int = x_int; v.x_tgt = x_tgt; v.x_svc = x_svc; v.x_ret = x_ret;
        v.x_id = x_id; v.x_pend = x_pend; v.x_cfg = x_cfg; v.x_spur = x_spur;
        return v;
    endfunction

    int ints_seen;

    initial begin
        // Directed table: inputs | int tgt svc ret id pend cfg spur (as seen before the edge)
        //                   irq     cv   mret  pcn       we   wd         int  tgt       svc  ret       id    pend     cfg        spur
        tbl[0]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 5'b10100, 1'b0, 16'h0010, 1'b0, 16'h0000, 3'd0, 4'b0000, 5'b00000, 1'b0);
        tbl[1]  = mk(4'b0100, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b0, 16'h0000, 3'd0, 4'b0000, 5'b10100, 1'b0);
        tbl[2]  = mk(4'b0000, 1'b1, 1'b0, 16'h0040, 1'b0, 5'b00000, 1'b1, 16'h0018, 1'b0, 16'h0000, 3'd0, 4'b0100, 5'b10100, 1'b0);
        tbl[3]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0040, 3'd2, 4'b0000, 5'b10100, 1'b0);
        tbl[4]  = mk(4'b0001, 1'b1, 1'b0, 16'h0050, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0040, 3'd2, 4'b0000, 5'b10100, 1'b0);
        tbl[5]  = mk(4'b0000, 1'b1, 1'b0, 16'h0060, 1'b1, 5'b11111, 1'b0, 16'h0010, 1'b1, 16'h0040, 3'd2, 4'b0001, 5'b10100, 1'b0);
        tbl[6]  = mk(4'b0000, 1'b1, 1'b1, 16'h0064, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0040, 3'd2, 4'b0001, 5'b11111, 1'b0);
        tbl[7]  = mk(4'b0000, 1'b1, 1'b0, 16'h0070, 1'b0, 5'b00000, 1'b1, 16'h0010, 1'b0, 16'h0040, 3'd2, 4'b0001, 5'b11111, 1'b0);
        tbl[8]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0070, 3'd0, 4'b0000, 5'b11111, 1'b0);
        tbl[9]  = mk(4'b0000, 1'b1, 1'b1, 16'h0074, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0070, 3'd0, 4'b0000, 5'b11111, 1'b0);
        tbl[10] = mk(4'b1010, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b0, 16'h0070, 3'd0, 4'b0000, 5'b11111, 1'b0);
        tbl[11] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0014, 1'b0, 16'h0070, 3'd0, 4'b1010, 5'b11111, 1'b0);
        tbl[12] = mk(4'b0000, 1'b1, 1'b0, 16'h0080, 1'b0, 5'b00000, 1'b1, 16'h0014, 1'b0, 16'h0070, 3'd0, 4'b1010, 5'b11111, 1'b0);
        tbl[13] = mk(4'b0000, 1'b1, 1'b1, 16'h0084, 1'b0, 5'b00000, 1'b0, 16'h001C, 1'b1, 16'h0080, 3'd1, 4'b1000, 5'b11111, 1'b0);
        tbl[14] = mk(4'b0000, 1'b1, 1'b0, 16'h0090, 1'b0, 5'b00000, 1'b1, 16'h001C, 1'b0, 16'h0080, 3'd1, 4'b1000, 5'b11111, 1'b0);
        tbl[15] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0090, 3'd3, 4'b0000, 5'b11111, 1'b0);
        tbl[16] = mk(4'b0000, 1'b1, 1'b1, 16'h0094, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h0090, 3'd3, 4'b0000, 5'b11111, 1'b0);
        tbl[17] = mk(4'b0010, 1'b0, 1'b0, 16'h0000, 1'b1, 5'b01111, 1'b0, 16'h0010, 1'b0, 16'h0090, 3'd3, 4'b0000, 5'b11111, 1'b0);
        tbl[18] = mk(4'b0000, 1'b1, 1'b0, 16'h00A0, 1'b0, 5'b00000, 1'b0, 16'h0014, 1'b0, 16'h0090, 3'd3, 4'b0010, 5'b01111, 1'b0);
        tbl[19] = mk(4'b0000, 1'b1, 1'b0, 16'h00A4, 1'b1, 5'b11111, 1'b0, 16'h0014, 1'b0, 16'h0090, 3'd3, 4'b0010, 5'b01111, 1'b0);
        tbl[20] = mk(4'b0000, 1'b1, 1'b0, 16'h00B0, 1'b0, 5'b00000, 1'b1, 16'h0014, 1'b0, 16'h0090, 3'd3, 4'b0010, 5'b11111, 1'b0);
        tbl[21] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h00B0, 3'd1, 4'b0000, 5'b11111, 1'b0);
        tbl[22] = mk(4'b0000, 1'b1, 1'b1, 16'h00B4, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b1, 16'h00B0, 3'd1, 4'b0000, 5'b11111, 1'b0);
        tbl[23] = mk(4'b0000, 1'b1, 1'b1, 16'h00C4, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b0, 16'h00B0, 3'd1, 4'b0000, 5'b11111, 1'b1);
        tbl[24] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0010, 1'b0, 16'h00B0, 3'd1, 4'b0000, 5'b11111, 1'b0);

        rst = 1'b1;
        irq_in = '0; commit_valid = 1'b0; mret_commit = 1'b0;
        pc_next = '0; cfg_we = 1'b0; cfg_wdata = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_isr_target", 32'(isr_target), 32'h0010);
        chk("rst_isr_return", 32'(isr_return), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_cfg_rdata", 32'(cfg_rdata), 32'd0);
        chk("rst_mret_spurious", 32'(mret_spurious), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int k = 0; k < 25; k++) begin
            step(tbl[k].irq, tbl[k].cv, tbl[k].mret, tbl[k].pcn, tbl[k].we, tbl[k].wd, 1'b0);
            chk($sformatf("tbl%0d_interrupt", k), 32'(interrupt), 32'(tbl[k].x_int));
            chk($sformatf("tbl%0d_isr_target", k), 32'(isr_target), 32'(tbl[k].x_tgt));
            chk($sformatf("tbl%0d_in_service", k), 32'(in_service), 32'(tbl[k].x_svc));
            chk($sformatf("tbl%0d_isr_return", k), 32'(isr_return), 32'(tbl[k].x_ret));
            chk($sformatf("tbl%0d_active_id", k), 32'(active_id), 32'(tbl[k].x_id));
            chk($sformatf("tbl%0d_pending", k), 32'(pending), 32'(tbl[k].x_pend));
            chk($sformatf("tbl%0d_cfg_rdata", k), 32'(cfg_rdata), 32'(tbl[k].x_cfg));
            chk($sformatf("tbl%0d_mret_spurious", k), 32'(mret_spurious), 32'(tbl[k].x_spur));
        end

        // Reset while a handler is active and another request is pending
        step(4'b0100, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 16'h00C0, 1'b0, 5'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 5'b0, 1'b1);
        chk("pre_rst_in_service", 32'(in_service), 32'd1);
        chk("pre_rst_pending", 32'(pending), 32'b0001);
        @(negedge clk);
        commit_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_in_service", 32'(in_service), 32'd0);
        chk("async_rst_pending", 32'(pending), 32'd0);
        chk("async_rst_isr_return", 32'(isr_return), 32'd0);
        chk("async_rst_interrupt", 32'(interrupt), 32'd0);
        commit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ints_seen = 0;
        step(4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 5'b11111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 1'b1, 1'b0, 16'(16'h0100 + k * 4), 1'b0, 5'b0, 1'b1);
            if (interrupt) ints_seen++;
        end
        chk("post_rst_no_take", 32'(ints_seen), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 16'($urandom) & 16'hFFFC,
                 ($urandom_range(0, 15) == 0),
                 {($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15))},
                 1'b1);
        end
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
